// File: rtl/msrv32_trap_sequencer_if.sv
// Trap sequencer bus: request/capture inputs from the core and the
// flush / CSR-write / PC-redirect controls produced by the sequencer.
//   master : core side, drives requests and CSR snapshots, observes controls
//   slave  : sequencer side
interface msrv32_trap_sequencer_if;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned CSR_AW  = 12;
    localparam int unsigned CAUSE_W = 5;

    logic                trap_req_in;
    logic                mret_req_in;
    logic [CAUSE_W-1:0]  trap_cause_in;
    logic [XLEN-1:0]     trap_pc_in;
    logic [XLEN-1:0]     mtvec_in;
    logic [XLEN-1:0]     mepc_in;
    logic                flush_out;
    logic                csr_wr_en_out;
    logic [CSR_AW-1:0]   csr_wr_addr_out;
    logic [XLEN-1:0]     csr_wr_data_out;
    logic                pc_redirect_out;
    logic [XLEN-1:0]     pc_redirect_addr_out;
    logic                trap_ack_out;
    logic                busy_out;

    modport master (
        output trap_req_in, mret_req_in, trap_cause_in, trap_pc_in, mtvec_in, mepc_in,
        input  flush_out, csr_wr_en_out, csr_wr_addr_out, csr_wr_data_out,
               pc_redirect_out, pc_redirect_addr_out, trap_ack_out, busy_out
    );

    modport slave (
        input  trap_req_in, mret_req_in, trap_cause_in, trap_pc_in, mtvec_in, mepc_in,
        output flush_out, csr_wr_en_out, csr_wr_addr_out, csr_wr_data_out,
               pc_redirect_out, pc_redirect_addr_out, trap_ack_out, busy_out
    );
endinterface

// File: rtl/msrv32_trap_sequencer.sv
// Trap / mret sequencer: drains the pipeline for FLUSH_CYCLES, writes mepc
// and mcause (trap only), then redirects the PC to the handler or to mepc.
// Ports:
//   ms_riscv32_mp_clk_in : clock, rising edge
//   ms_riscv32_mp_rst_in : asynchronous reset, active high
//   bus (slave)          : requests + CSR snapshots in; flush, CSR write,
//                          redirect, ack and busy out (all registered)
module msrv32_trap_sequencer #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                    ms_riscv32_mp_clk_in,
    input  logic                    ms_riscv32_mp_rst_in,
    msrv32_trap_sequencer_if.slave  bus
);
    localparam int unsigned XLEN    = 32;
    localparam int unsigned CSR_AW  = 12;
    localparam int unsigned CAUSE_W = 5;
    localparam int unsigned CNT_W   = 4;
    localparam logic [CSR_AW-1:0] ADDR_MEPC   = 12'h341;
    localparam logic [CSR_AW-1:0] ADDR_MCAUSE = 12'h342;

    typedef enum logic [2:0] {
        S_IDLE, S_FLUSH, S_WR_EPC, S_WR_CAUSE, S_REDIRECT
    } state_t;

    state_t              state_q, state_d;
    logic                is_trap_q, is_trap_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]     epc_q, epc_d;
    logic [CAUSE_W-1:0]  cause_q, cause_d;
    logic [XLEN-1:0]     target_q, target_d;

    logic                flush_q, flush_d;
    logic                wr_en_q, wr_en_d;
    logic [CSR_AW-1:0]   wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]     wr_data_q, wr_data_d;
    logic                redir_q, redir_d;
    logic [XLEN-1:0]     redir_addr_q, redir_addr_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;

    // Handler target resolved at capture time so later states only replay registers.
    logic [XLEN-1:0]     trap_base_c;
    logic                vectored_c;
    logic [XLEN-1:0]     trap_target_c;

    always_comb begin
        trap_base_c   = {bus.mtvec_in[XLEN-1:2], 2'b00};
        vectored_c    = (bus.mtvec_in[1:0] == 2'b01) && bus.trap_cause_in[4];
        trap_target_c = vectored_c ? (trap_base_c + XLEN'({bus.trap_cause_in[3:0], 2'b00}))
                                   : trap_base_c;
    end

    // Next-state, capture and next-output logic; outputs are registered from the next state.
    always_comb begin
        state_d      = state_q;
        is_trap_d    = is_trap_q;
        cnt_d        = cnt_q;
        epc_d        = epc_q;
        cause_d      = cause_q;
        target_d     = target_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = '0;
        wr_data_d    = '0;
        redir_d      = 1'b0;
        redir_addr_d = '0;

        case (state_q)
            S_IDLE: begin
                // Trap has priority; a simultaneous mret is dropped.
                if (bus.trap_req_in) begin
                    state_d   = S_FLUSH;
                    is_trap_d = 1'b1;
                    cnt_d     = CNT_W'(FLUSH_CYCLES - 1);
                    epc_d     = {bus.trap_pc_in[XLEN-1:2], 2'b00};
                    cause_d   = bus.trap_cause_in;
                    target_d  = trap_target_c;
                end else if (bus.mret_req_in) begin
                    state_d   = S_FLUSH;
                    is_trap_d = 1'b0;
                    cnt_d     = CNT_W'(FLUSH_CYCLES - 1);
                    target_d  = {bus.mepc_in[XLEN-1:2], 2'b00};
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = is_trap_q ? S_WR_EPC : S_REDIRECT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WR_EPC:   state_d = S_WR_CAUSE;
            S_WR_CAUSE: state_d = S_REDIRECT;
            S_REDIRECT: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        flush_d = (state_d != S_IDLE);
        busy_d  = (state_d != S_IDLE);
        ack_d   = (state_q == S_IDLE) && (state_d == S_FLUSH);

        case (state_d)
            S_WR_EPC: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ADDR_MEPC;
                wr_data_d = epc_d;
            end
            S_WR_CAUSE: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ADDR_MCAUSE;
                wr_data_d = {cause_d[4], 27'b0, cause_d[3:0]};
            end
            S_REDIRECT: begin
                redir_d      = 1'b1;
                redir_addr_d = target_d;
            end
            default: ;
        endcase
    end

    // State, captured data and output registers; reset discards everything.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q      <= S_IDLE;
            is_trap_q    <= 1'b0;
            cnt_q        <= '0;
            epc_q        <= '0;
            cause_q      <= '0;
            target_q     <= '0;
            flush_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            redir_q      <= 1'b0;
            redir_addr_q <= '0;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_trap_q    <= is_trap_d;
            cnt_q        <= cnt_d;
            epc_q        <= epc_d;
            cause_q      <= cause_d;
            target_q     <= target_d;
            flush_q      <= flush_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            redir_q      <= redir_d;
            redir_addr_q <= redir_addr_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.flush_out            = flush_q;
    assign bus.csr_wr_en_out        = wr_en_q;
    assign bus.csr_wr_addr_out      = wr_addr_q;
    assign bus.csr_wr_data_out      = wr_data_q;
    assign bus.pc_redirect_out      = redir_q;
    assign bus.pc_redirect_addr_out = redir_addr_q;
    assign bus.trap_ack_out         = ack_q;
    assign bus.busy_out             = busy_q;
endmodule

// File: doc/msrv32_trap_sequencer.md
MSRV32_TRAP_SEQUENCER -- requirements
Module: msrv32_trap_sequencer

Interface
REQ-001 Parameter SHALL be: FLUSH_CYCLES, 2, number of pipeline-drain cycles; legal range 1..15.
REQ-002 Clocking SHALL be one clock with an asynchronous, active-high reset.
REQ-003 ms_riscv32_mp_clk_in  in  1  sole clock; all state changes on its rising edge.
REQ-004 ms_riscv32_mp_rst_in  in  1  asynchronous reset, active-high.
REQ-005 trap_req_in  in  1  exception/interrupt request (level); sampled only in IDLE.
REQ-006 mret_req_in  in  1  mret request (level); sampled only in IDLE.
REQ-007 trap_cause_in  in  5  bit4 = interrupt flag; bits[3:0] = cause code.
REQ-008 trap_pc_in  in  32  PC of the trapping instruction.
REQ-009 mtvec_in  in  32  current mtvec CSR value.
REQ-010 mepc_in  in  32  current mepc CSR value.
REQ-011 flush_out  out  1  drives flush_in of the write-enable generator.
REQ-012 csr_wr_en_out  out  1  dedicated CSR-file write strobe; not gated by flush.
REQ-013 csr_wr_addr_out  out  12  CSR write address.
REQ-014 csr_wr_data_out  out  32  CSR write data.
REQ-015 pc_redirect_out  out  1  one-cycle PC-load strobe.
REQ-016 pc_redirect_addr_out  out  32  PC load target.
REQ-017 trap_ack_out  out  1  one-cycle acceptance pulse.
REQ-018 busy_out  out  1  high in every state other than IDLE.

Function
REQ-019 FSM states SHALL be: IDLE, FLUSH, WR_EPC, WR_CAUSE, REDIRECT; all outputs decoded from registered state and registers (no input-to-output combinational path).
REQ-020 IDLE, trap_req_in=1 at edge: go to FLUSH, mode=TRAP, capture trap_pc_in, trap_cause_in and mtvec_in, load counter with FLUSH_CYCLES-1.
REQ-021 IDLE, mret_req_in=1 and trap_req_in=0 at edge: go to FLUSH, mode=MRET, capture mepc_in, load counter.
REQ-022 Both requests high in the same IDLE cycle: trap SHALL win; the mret is dropped, not queued.
REQ-023 Requests arriving in any state other than IDLE SHALL be ignored and not queued.
REQ-024 trap_ack_out SHALL be high for exactly the first FLUSH cycle of each accepted request, trap or mret.
REQ-025 FLUSH: counter decrements each cycle; at counter=0, next state is WR_EPC (TRAP) or REDIRECT (MRET); FLUSH therefore lasts exactly FLUSH_CYCLES cycles.
REQ-026 WR_EPC (1 cycle): csr_wr_en_out=1, addr=12'h341, data={captured_pc[31:2],2'b00}.
REQ-027 WR_CAUSE (1 cycle): csr_wr_en_out=1, addr=12'h342, data={cause[4],27'b0,cause[3:0]}.
REQ-028 REDIRECT (1 cycle): pc_redirect_out=1; next state IDLE.
REQ-029 TRAP target: base={mtvec[31:2],2'b00}; if mtvec[1:0]=2'b01 and cause[4]=1, target=base+{cause[3:0],2'b00}, modulo 2^32; otherwise target=base.
REQ-030 MRET target: captured mepc with bits[1:0] cleared.
REQ-031 flush_out SHALL be 1 in FLUSH, WR_EPC, WR_CAUSE and REDIRECT, and 0 in IDLE.
REQ-032 Outside WR_EPC/WR_CAUSE: csr_wr_en_out=0, csr_wr_addr_out=0, csr_wr_data_out=0. Outside REDIRECT: pc_redirect_out=0, pc_redirect_addr_out=0.
REQ-033 Busy duration SHALL be FLUSH_CYCLES+3 cycles for a trap and FLUSH_CYCLES+1 cycles for an mret; a new request is acceptable on the first IDLE cycle after REDIRECT.

Reset
REQ-034 While ms_riscv32_mp_rst_in=1, state SHALL be IDLE, all registers 0, and all outputs 0, applied asynchronously.
REQ-035 Reset mid-sequence SHALL abort immediately: no further CSR write and no redirect; captured data is discarded.
REQ-036 After reset deasserts, the first edge SHALL already sample requests in IDLE.

Verification (FLUSH_CYCLES=2)
REQ-037 Reset with random inputs -> every output 0 during reset, busy_out=0 on release.
REQ-038 trap_req_in=1, cause=5'h02, pc=0x0000_0107, mtvec=0x0000_0200 -> ack in cycle 1; flush_out high for 5 cycles; 341 <- 0x0000_0104; 342 <- 0x0000_0002; redirect to 0x0000_0200.
REQ-039 cause=5'h17, mtvec=0x0000_0301 -> 342 <- 0x8000_0007; redirect to 0x0000_031C.
REQ-040 mret_req_in=1, mepc=0x0000_0108 -> flush_out high for 3 cycles; csr_wr_en_out never high; redirect to 0x0000_0108.
REQ-041 trap and mret in the same cycle, then a second trap during FLUSH -> exactly one trap sequence; the second trap gets no ack.
REQ-042 Reset asserted during WR_CAUSE -> outputs 0 without waiting for an edge; pc_redirect_out never pulses.
